stage_if_fetch: RTL and testbench
=================================

# stage_if_fetch

Instruction-fetch stage. Generates the sequential PC, issues in-order requests to instruction memory, and buffers returned words in a small show-ahead FIFO. It drives `inst`/`pc`/`inst_valid` into the IF→ID register of the decode stage. It consumes the decode stage's stall and PC-override redirect, discarding every response that was in flight at the time of the redirect.

## Interface
- `ADDR_WIDTH`, 64: PC and memory address width.
- `INST_WIDTH`, 32: instruction word width.
- `RESET_PC`, 0: first fetch address after reset.
- `FIFO_DEPTH`, 2: fetch-buffer entries and the maximum number of outstanding requests.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; state is reset on any rising edge where `reset`=0.
- `stall` in 1: decode cannot accept (OR of load_stall, buffer_stall, external stall).
- `redirect` in 1: PC override from decode (branch mispredict, jump, interrupt).
- `redirect_pc` in ADDR_WIDTH: new fetch target; bits [1:0] are ignored and forced to 0.
- `imem_req_valid` out 1: request valid.
- `imem_req_addr` out ADDR_WIDTH: request address; equals `fetch_pc`.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response word valid. Responses arrive in order, with at least 1 cycle latency, and carry no backpressure.
- `imem_rsp_data` in INST_WIDTH: returned instruction.
- `inst_valid` out 1: FIFO head is valid for decode.
- `inst` out INST_WIDTH: FIFO head instruction.
- `pc` out ADDR_WIDTH: FIFO head PC.

## Operation
- State:
  - `fetch_pc`.
  - FIFO of {pc, inst} with `count`.
  - A queue of the PCs of issued requests, or equivalently the PC of each request captured at accept.
  - `outstanding` (0..FIFO_DEPTH).
  - `drop_cnt` (0..FIFO_DEPTH).
- Definitions:
  - accept = `imem_req_valid & imem_req_ready`.
  - pop = `inst_valid & ~stall & ~redirect`.
  - keep_rsp = `imem_rsp_valid & (drop_cnt==0) & ~redirect`.
- Credit: `imem_req_valid` = (reset=1) & (outstanding + count − pop < FIFO_DEPTH) & ~redirect. This guarantees every kept response has a FIFO slot.
- On accept: `fetch_pc` += 4, wrapping modulo 2^ADDR_WIDTH. The request's PC is recorded in the in-order PC queue.
- On `imem_rsp_valid`: `outstanding` decrements. If keep_rsp, {queued PC, data} is pushed. Otherwise the response is discarded and `drop_cnt` decrements if it is nonzero.
- `inst_valid` = (count≠0) & ~redirect. `inst`/`pc` come combinationally from the FIFO head.
- Redirect (edge with `redirect`=1):
  - The FIFO is cleared.
  - `fetch_pc` ← {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - `drop_cnt` ← outstanding + accept − imem_rsp_valid, evaluated that cycle. Accept is 0 because valid is gated, so this equals the number of responses still owed.
  - The PC queue is cleared of discarded entries.
- `redirect` has priority over `stall`, push, and pop.
- `stall` never blocks issue directly. Fetching continues until credit is exhausted.
- `drop_cnt` and kept responses interleave correctly: the first `drop_cnt` responses after a redirect are always discarded.

## Timing
- Reset values:
  - `inst_valid`=0, `imem_req_valid`=0, `inst`=0, `pc`=0.
  - `imem_req_addr`=RESET_PC.
  - count=0, outstanding=0, drop_cnt=0.
- First request: the cycle after `reset` returns to 1.
- Latency: request accepted at cycle N with response at N+1 gives `inst_valid` at N+2.
- Throughput: 1 instruction/cycle with 1-cycle memory and `stall`=0, using FIFO_DEPTH=2.
- After a redirect at cycle R, the first request to the target issues at R+1. The corresponding `inst_valid` comes no earlier than R+3.
- A redirect arriving in the same cycle as a response discards that response.
- Reset mid-operation clears all state. Responses arriving after reset are not tracked. The memory is reset with the same `reset`.

## Test plan
- Reset with RESET_PC=0x1000 and `reset` low for 3 cycles.
  - Required: all outputs at reset values.
  - After release: requests 0x1000, 0x1004, 0x1008 issue on consecutive cycles.
- Stream with 1-cycle memory (data = addr ^ 0xA5A5A5A5) and `stall`=0.
  - Required: `inst_valid` continuously high from cycle 3.
  - `pc` increments by 4 each cycle and `inst` matches data.
- Hold `stall`=1 for 5 cycles mid-stream.
  - Required: `pc`/`inst` hold the same value.
  - Outstanding + count never exceeds 2 and `imem_req_valid` drops.
  - After release, no instruction is lost or duplicated.
- With 2 requests outstanding (3-cycle memory), assert `redirect` with `redirect_pc`=0x2003.
  - Required: both old responses discarded and the next request address is 0x2000.
  - The first `inst_valid` shows pc=0x2000.
- Redirect in the same cycle as `imem_rsp_valid` and `stall`=1.
  - Required: the response is dropped and the FIFO is empty the next cycle.
- Start with `fetch_pc`=2^64−4 (via redirect).
  - Required: the next address is 0x0.
- `reset` asserted mid-stream with count=2.
  - Required: `inst_valid`=0 on the next edge.

Source files
------------

// File: rtl/stage_if_fetch_if.sv
// Instruction-memory port of the fetch stage: in-order request channel plus
// a response channel that carries no backpressure.
interface stage_if_fetch_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  // Request transfers on a cycle where imem_req_valid & imem_req_ready; addr is
  // stable while valid is high. Responses return in request order, at least one
  // cycle later, one word per cycle where imem_rsp_valid is high.
  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/stage_if_fetch.sv
// Instruction fetch: sequential PC generation, credit-limited in-order memory
// requests, and a show-ahead buffer feeding decode, with redirect flushing.
module stage_if_fetch #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               redirect,
  input  logic [ADDR_WIDTH-1:0]              redirect_pc,
  stage_if_fetch_if.master                   imem,
  output logic                               inst_valid,
  output logic [INST_WIDTH-1:0]              inst,
  output logic [ADDR_WIDTH-1:0]              pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    dbg_count_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    dbg_outstanding_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    dbg_drop_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_q       [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

  logic          pop, accept, keep_rsp, rsp_dec, credit;
  logic [CW:0]   used;
  logic          unused_pc_lsbs;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign inst_valid = (count_q != '0) & ~redirect;
  assign inst       = fifo_inst_q[rd_ptr_q];
  assign pc         = fifo_pc_q[rd_ptr_q];
  assign pop        = inst_valid & ~stall & ~redirect;

  // Credit counts both in-flight requests and buffered words, so every kept
  // response is guaranteed a free slot without memory backpressure.
  assign used     = {1'b0, outstanding_q} + {1'b0, count_q} - (CW + 1)'(pop);
  assign credit   = used < (CW + 1)'(FIFO_DEPTH);

  assign imem.imem_req_valid = reset & credit & ~redirect;
  assign imem.imem_req_addr  = fetch_pc_q;
  assign accept   = imem.imem_req_valid & imem.imem_req_ready;
  assign keep_rsp = imem.imem_rsp_valid & (drop_cnt_q == '0) & ~redirect;
  assign rsp_dec  = imem.imem_rsp_valid & (outstanding_q != '0);

  assign dbg_count_o       = count_q;
  assign dbg_outstanding_o = outstanding_q;
  assign dbg_drop_cnt_o    = drop_cnt_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pcq_rd_d      = pcq_rd_q;
    pcq_wr_d      = pcq_wr_q;

    if (accept)  outstanding_d = outstanding_d + ONE;
    if (rsp_dec) outstanding_d = outstanding_d - ONE;

    if (redirect) begin
      // Everything still owed by memory after this edge belongs to the old path.
      fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      drop_cnt_d = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      pcq_rd_d   = '0;
      pcq_wr_d   = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        pcq_wr_d   = nxt(pcq_wr_q);
      end
      if (keep_rsp) begin
        count_d  = count_d + ONE;
        wr_ptr_d = nxt(wr_ptr_q);
        pcq_rd_d = nxt(pcq_rd_q);
      end else if (imem.imem_rsp_valid && drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - ONE;
      end
      if (pop) begin
        count_d  = count_d - ONE;
        rd_ptr_d = nxt(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pcq_rd_q      <= pcq_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      if (keep_rsp) begin
        fifo_pc_q[wr_ptr_q]   <= pcq_q[pcq_rd_q];
        fifo_inst_q[wr_ptr_q] <= imem.imem_rsp_data;
      end
      if (accept) pcq_q[pcq_wr_q] <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_stage_if_fetch.sv
// Directed bench for stage_if_fetch: a cycle table for reset/issue/stall/redirect
// timing, then memory-model sequences for streaming, flushes, wrap and reset.
module tb_stage_if_fetch;
  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [AW-1:0] RST_PC = 64'h1000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] pc;
  logic [1:0]    dbg_count, dbg_out, dbg_drop;

  stage_if_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) imem_bus ();

  stage_if_fetch #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RST_PC), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem_bus), .inst_valid(inst_valid),
    .inst(inst), .pc(pc), .dbg_count_o(dbg_count),
    .dbg_outstanding_o(dbg_out), .dbg_drop_cnt_o(dbg_drop)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit use_model = 1'b0;
  bit sb_en     = 1'b0;
  int mem_lat   = 1;
  logic mem_ready = 1'b1;
  logic [AW-1:0] mq_addr[$];
  int            mq_due[$];
  logic [AW-1:0] exp_q[$];

  logic          s_req_v, s_iv;
  logic [AW-1:0] s_addr, s_pc;
  logic [IW-1:0] s_inst;
  logic [1:0]    s_cnt, s_out;

  function automatic logic [IW-1:0] dfun(input logic [AW-1:0] a);
    return a[31:0] ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: one cycle, inputs applied just after negedge, outputs sampled 1ns later
  task automatic run_cycle(input logic rst_n, input logic st, input logic rd,
                           input logic [AW-1:0] rpc, input logic m_v,
                           input logic [IW-1:0] m_d);
    logic [AW-1:0] e;
    reset = rst_n; stall = st; redirect = rd; redirect_pc = rpc;
    imem_bus.imem_req_ready = mem_ready;
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
    end
    if (use_model) begin
      if (mq_due.size() > 0 && mq_due[0] == cyc) begin
        imem_bus.imem_rsp_valid = 1'b1;
        imem_bus.imem_rsp_data  = dfun(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = '0;
      end
    end else begin
      imem_bus.imem_rsp_valid = m_v;
      imem_bus.imem_rsp_data  = m_d;
    end
    #1;
    s_req_v = imem_bus.imem_req_valid; s_addr = imem_bus.imem_req_addr;
    s_iv = inst_valid; s_pc = pc; s_inst = inst; s_cnt = dbg_count; s_out = dbg_out;
    // scoreboard: every instruction decode takes must be the next expected one
    if (sb_en && s_iv && !st && !rd) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb.extra: got pc 0x%0h expected none (cycle %0d)", s_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb.pc", s_pc, e);
        chk("sb.inst", {32'h0, s_inst}, {32'h0, dfun(e)});
      end
    end
    if (use_model && rst_n && s_req_v && mem_ready) begin
      mq_addr.push_back(s_addr);
      mq_due.push_back(cyc + mem_lat);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic reset_dut(input int n);
    exp_q.delete();
    sb_en = 1'b0;
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  typedef struct {
    logic rst_n; logic st; logic rd; logic [AW-1:0] rpc;
    logic rv; logic [IW-1:0] rdat;
    logic e_req_v; logic [AW-1:0] e_addr; logic e_iv;
    logic [AW-1:0] e_pc; logic [IW-1:0] e_inst; int e_cnt; logic chk_head;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int k;
    bit saw_drop, got_acc, got_iv;
    logic [AW-1:0] hold_pc;
    logic [IW-1:0] hold_inst;

    imem_bus.imem_req_ready = 1'b1;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = '0;

    // Table: reset, issue 1000/1004/1008, stall, redirect with same-cycle response
    tbl[0]  = '{1'b0,1'b0,1'b0,64'h0,   1'b0,32'h0,         1'b0,64'h1000,1'b0,64'h0,   32'h0,         0,1'b1};
    tbl[1]  = '{1'b0,1'b0,1'b0,64'h0,   1'b0,32'h0,         1'b0,64'h1000,1'b0,64'h0,   32'h0,         0,1'b1};
    tbl[2]  = '{1'b0,1'b0,1'b0,64'h0,   1'b0,32'h0,         1'b0,64'h1000,1'b0,64'h0,   32'h0,         0,1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b0,64'h0,   1'b0,32'h0,         1'b1,64'h1000,1'b0,64'h0,   32'h0,         0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,64'h0,   1'b1,dfun(64'h1000),1'b1,64'h1004,1'b0,64'h0,   32'h0,         0,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,64'h0,   1'b1,dfun(64'h1004),1'b1,64'h1008,1'b1,64'h1000,dfun(64'h1000),1,1'b1};
    tbl[6]  = '{1'b1,1'b1,1'b0,64'h0,   1'b1,dfun(64'h1008),1'b0,64'h100c,1'b1,64'h1004,dfun(64'h1004),1,1'b1};
    tbl[7]  = '{1'b1,1'b1,1'b0,64'h0,   1'b0,32'h0,         1'b0,64'h100c,1'b1,64'h1004,dfun(64'h1004),2,1'b1};
    tbl[8]  = '{1'b1,1'b0,1'b0,64'h0,   1'b0,32'h0,         1'b1,64'h100c,1'b1,64'h1004,dfun(64'h1004),2,1'b1};
    tbl[9]  = '{1'b1,1'b0,1'b0,64'h0,   1'b1,dfun(64'h100c),1'b1,64'h1010,1'b1,64'h1008,dfun(64'h1008),1,1'b1};
    tbl[10] = '{1'b1,1'b1,1'b1,64'h2003,1'b1,dfun(64'h1010),1'b0,64'h1014,1'b0,64'h100c,dfun(64'h100c),1,1'b1};
    tbl[11] = '{1'b1,1'b0,1'b0,64'h0,   1'b0,32'h0,         1'b1,64'h2000,1'b0,64'h0,   32'h0,         0,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,64'h0,   1'b1,dfun(64'h2000),1'b1,64'h2004,1'b0,64'h0,   32'h0,         0,1'b0};
    tbl[13] = '{1'b1,1'b0,1'b0,64'h0,   1'b1,dfun(64'h2004),1'b1,64'h2008,1'b1,64'h2000,dfun(64'h2000),1,1'b1};

    @(negedge clk);
    use_model = 1'b0;
    for (int i = 0; i < 14; i++) begin
      run_cycle(tbl[i].rst_n, tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rv, tbl[i].rdat);
      chk($sformatf("tbl[%0d].req_valid", i), {63'h0, s_req_v}, {63'h0, tbl[i].e_req_v});
      chk($sformatf("tbl[%0d].req_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("tbl[%0d].inst_valid", i), {63'h0, s_iv}, {63'h0, tbl[i].e_iv});
      chk($sformatf("tbl[%0d].count", i), {62'h0, s_cnt}, 64'(tbl[i].e_cnt));
      if (tbl[i].chk_head) begin
        chk($sformatf("tbl[%0d].pc", i), s_pc, tbl[i].e_pc);
        chk($sformatf("tbl[%0d].inst", i), {32'h0, s_inst}, {32'h0, tbl[i].e_inst});
      end
    end

    // A: 1-cycle memory stream with a 5-cycle stall window
    use_model = 1'b1; mem_lat = 1;
    reset_dut(3);
    for (int i = 0; i < 40; i++) exp_q.push_back(RST_PC + 64'(4 * i));
    sb_en = 1'b1; saw_drop = 1'b0; hold_pc = '0; hold_inst = '0;
    for (int i = 0; i < 30; i++) begin
      run_cycle(1'b1, (i >= 12 && i < 17), 1'b0, '0, 1'b0, '0);
      chk("A.credit", {63'h0, (32'(s_out) + 32'(s_cnt)) <= 2}, 64'h1);
      if (i >= 2) chk("A.inst_valid", {63'h0, s_iv}, 64'h1);
      if (i == 12) begin hold_pc = s_pc; hold_inst = s_inst; end
      if (i > 12 && i < 17) begin
        chk("A.hold_pc", s_pc, hold_pc);
        chk("A.hold_inst", {32'h0, s_inst}, {32'h0, hold_inst});
        if (!s_req_v) saw_drop = 1'b1;
      end
    end
    chk("A.req_drop_in_stall", {63'h0, saw_drop}, 64'h1);
    chk("A.consumed", 64'(40 - exp_q.size()), 64'd23);

    // B: 3-cycle memory, redirect with two responses owed
    mem_lat = 3;
    reset_dut(2);
    k = 0;
    while (dbg_out != 2'd2 && k < 10) begin idle(1); k++; end
    chk("B.two_outstanding", {62'h0, dbg_out}, 64'd2);
    run_cycle(1'b1, 1'b0, 1'b1, 64'h2003, 1'b0, '0);
    chk("B.redirect_req_valid", {63'h0, s_req_v}, 64'h0);
    chk("B.drop_cnt", {62'h0, dbg_drop}, 64'd2);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'h2000 + 64'(4 * i));
    sb_en = 1'b1; got_acc = 1'b0; got_iv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      if (i == 0) chk("B.addr_after_redirect", s_addr, 64'h2000);
      if (!got_acc && s_req_v) begin got_acc = 1'b1; chk("B.first_req", s_addr, 64'h2000); end
      if (!got_iv && s_iv) begin got_iv = 1'b1; chk("B.first_iv_pc", s_pc, 64'h2000); end
    end
    chk("B.saw_inst", {63'h0, got_iv}, 64'h1);
    chk("B.drop_done", {62'h0, dbg_drop}, 64'd0);

    // C: wrap of the fetch PC at the top of the address space
    mem_lat = 1;
    reset_dut(2);
    run_cycle(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 6; i++) exp_q.push_back(64'(4 * i));
    sb_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      if (i == 0) chk("C.addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      if (i == 1) chk("C.addr_wrap", s_addr, 64'h0);
    end
    chk("C.consumed", 64'(exp_q.size()), 64'd2);

    // D: reset while the buffer is full
    reset_dut(2);
    k = 0;
    while (dbg_count != 2'd2 && k < 10) begin
      run_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
      k++;
    end
    chk("D.count_full", {62'h0, dbg_count}, 64'd2);
    run_cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("D.inst_valid_after_reset", {63'h0, inst_valid}, 64'h0);
    chk("D.count_after_reset", {62'h0, dbg_count}, 64'd0);
    chk("D.outstanding_after_reset", {62'h0, dbg_out}, 64'd0);
    chk("D.pc_after_reset", pc, 64'h0);
    run_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("D.first_req_after_reset", s_addr, RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
